voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice allocator that turns a stream of note-on/note-off events into per-voice note, velocity, gate and trigger signals. It sits upstream of the oscillator/envelope voices, whose sample outputs are later summed by the voice mixer. A new note reuses a voice already playing the same note, else takes the lowest-index free voice, else steals the least-recently-assigned voice. Each event is processed by a sequential scan of the voices, one voice per cycle.

## Interface
- NUM_VOICES, 8, number of voices; power of 2, ≥2
- NOTE_WIDTH, 7, note number width
- VEL_WIDTH, 7, velocity width
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-low reset
- event_valid  in  1  event present
- event_ready  out  1  allocator can accept an event
- event_on  in  1  1 = note-on, 0 = note-off
- event_note  in  NOTE_WIDTH  note number
- event_velocity  in  VEL_WIDTH  velocity; 0 on a note-on means note-off
- panic  in  1  all-notes-off request
- voice_gate  out  NUM_VOICES  per-voice gate
- voice_trigger  out  NUM_VOICES  one-cycle pulse when a voice is (re)assigned
- voice_steal  out  1  one-cycle pulse when the assignment stole a gated voice
- voice_note  out  NUM_VOICES × NOTE_WIDTH  per-voice note
- voice_velocity  out  NUM_VOICES × VEL_WIDTH  per-voice velocity

## Operation
- FSM states:
  - IDLE: event_ready = 1. On event_valid, latch the event and go to SCAN with idx = 0.
  - SCAN: examine voice idx and increment idx. After idx = NUM_VOICES-1, go to COMMIT.
  - COMMIT: apply the result and return to IDLE.
- Note-on with velocity ≠ 0. Priority:
  1. A gated voice whose note equals event_note is retriggered. Update its velocity; no steal.
  2. Otherwise, the lowest-index voice with gate = 0 takes the note.
  3. Otherwise, the voice with age = NUM_VOICES-1 takes the note and voice_steal pulses.
  - The chosen voice gets gate = 1, note, velocity and a trigger pulse.
- Note-off, or note-on with velocity = 0:
  - The gated voice with a matching note gets gate = 0.
  - note and velocity hold their values.
  - No trigger pulse.
  - If no voice matches, nothing changes.
- Ages are an LRU permutation of 0..NUM_VOICES-1.
  - The assigned voice (including a retrigger) gets age 0.
  - Every voice whose age was below its old age is incremented.
  - Reset value: age[i] = i.
  - Note-off does not change ages.
- panic: at the next edge, in any state, all gates go to 0 and any in-flight event is dropped (FSM goes to IDLE). No triggers, ages unchanged. panic has priority over COMMIT.
- At most one voice holds a given gated note at any time.

## Timing
- Accept at edge T (event_valid ∧ event_ready).
- SCAN occupies cycles T+1 .. T+NUM_VOICES.
- COMMIT at cycle T+NUM_VOICES+1.
- Updated gate/note/velocity, plus the trigger and steal pulses, are visible together in cycle T+NUM_VOICES+2.
- event_ready is low for NUM_VOICES+1 cycles after accept; throughput is one event per NUM_VOICES+2 cycles.
- voice_trigger and voice_steal are high for exactly one cycle.
- While rst = 0, all of the following hold:
  - voice_gate, voice_trigger, voice_steal, voice_note and voice_velocity are 0.
  - event_ready = 0, FSM = IDLE, ages reset.
  - event_ready rises in the first cycle after reset is released.
- A reset mid-scan drops the event.
- An event presented together with panic in IDLE is dropped; event_ready remains 1.

## Structure
- Shared package synth_pkg holds:
  - voice_alloc_state_t enum (IDLE, SCAN, COMMIT)
  - default NOTE_WIDTH/VEL_WIDTH constants
- Sub-module voice_age_tracker holds the LRU age permutation.
  - Inputs: touch strobe and voice index.
  - Outputs: per-voice ages and the oldest index.
- The scan index has width $clog2(NUM_VOICES).

## Test plan
- **Reset release, then note-on 60 / velocity 100:** voice 0 gated with note 60, trigger[0] pulses at T+10 (NUM_VOICES = 8), event_ready low for 9 cycles.
- **Note-ons 60 and 62, then note-off 60:** voice 0 gate = 0, voice 1 still gated, note[0] stays 60, no trigger.
- **Note-on 60 while 60 is already in voice 3:** voice 3 retriggered with the new velocity; no other voice changes; voice_steal = 0.
- **Nine distinct note-ons (notes 40–48):** the ninth steals voice 0 (the oldest). voice_steal pulses with trigger[0], note[0] = 48.
- **Note-on with velocity 0 for a held note; note-off for an unheld note:** the held note's gate clears; the unheld note-off changes nothing.
- **panic asserted mid-SCAN with four voices gated:** all gates 0 next cycle, the event is dropped, no trigger, event_ready = 1 in the following cycle.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: allocator FSM encoding and default field widths.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } voice_alloc_state_t;

    localparam int DEFAULT_NUM_VOICES = 8;
    localparam int DEFAULT_NOTE_WIDTH = 7;
    localparam int DEFAULT_VEL_WIDTH  = 7;

endpackage

// File: rtl/voice_allocator_if.sv
// Event stream and per-voice control bundle between the note source and the allocator.
interface voice_allocator_if
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
    parameter int VEL_WIDTH  = DEFAULT_VEL_WIDTH,
    localparam int IW        = $clog2(NUM_VOICES)
) ();

    // Handshake: an event transfers on a rising clk edge where event_valid and
    // event_ready are both 1; the source holds the event fields stable while
    // event_valid is high and ready is low, and the allocator never drops an
    // accepted event except on panic or reset.
    logic                             event_valid;
    logic                             event_ready;
    logic                             event_on;
    logic [NOTE_WIDTH-1:0]            event_note;
    logic [VEL_WIDTH-1:0]             event_velocity;
    logic                             panic;

    logic [NUM_VOICES-1:0]            voice_gate;
    logic [NUM_VOICES-1:0]            voice_trigger;
    logic                             voice_steal;
    logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note;
    logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_velocity;

    // Observation only: FSM state and the LRU age of every voice.
    voice_alloc_state_t               fsm_state;
    logic [NUM_VOICES*IW-1:0]         voice_age;

    modport master (
        output event_valid, event_on, event_note, event_velocity, panic,
        input  event_ready, voice_gate, voice_trigger, voice_steal,
               voice_note, voice_velocity, fsm_state, voice_age
    );

    modport slave (
        input  event_valid, event_on, event_note, event_velocity, panic,
        output event_ready, voice_gate, voice_trigger, voice_steal,
               voice_note, voice_velocity, fsm_state, voice_age
    );

endinterface

// File: rtl/voice_age_tracker.sv
// LRU age permutation: a touched voice becomes age 0, younger voices age by one.
module voice_age_tracker #(
    parameter int NUM_VOICES = 8,
    localparam int IW        = $clog2(NUM_VOICES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           touch_i,
    input  logic [IW-1:0]                  touch_idx_i,
    output logic [NUM_VOICES-1:0][IW-1:0]  ages_o,
    output logic [IW-1:0]                  oldest_o
);

    logic [NUM_VOICES-1:0][IW-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (touch_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IW'(i) == touch_idx_i) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[touch_idx_i]) begin
                    age_d[i] = age_q[i] + IW'(1);
                end
            end
        end
    end

    // The ages stay a permutation, so exactly one voice carries the top age.
    always_comb begin
        oldest_o = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (age_q[i] == IW'(NUM_VOICES - 1)) oldest_o = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= IW'(i);
        end else begin
            age_q <= age_d;
        end
    end

    assign ages_o = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans voices one per cycle, then commits a
// retrigger, free-voice assignment, LRU steal or note release.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
    parameter int VEL_WIDTH  = DEFAULT_VEL_WIDTH,
    localparam int IW        = $clog2(NUM_VOICES)
) (
    input  logic              clk,
    input  logic              rst,
    voice_allocator_if.slave  ev_if
);

    voice_alloc_state_t              state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic                            on_q, on_d;
    logic [NOTE_WIDTH-1:0]           note_q, note_d;
    logic [VEL_WIDTH-1:0]            vel_q, vel_d;
    logic                            match_found_q, match_found_d;
    logic [IW-1:0]                   match_idx_q, match_idx_d;
    logic                            free_found_q, free_found_d;
    logic [IW-1:0]                   free_idx_q, free_idx_d;
    logic [NUM_VOICES-1:0]           gate_q, gate_d;
    logic [NUM_VOICES-1:0]           trig_q, trig_d;
    logic                            steal_q, steal_d;
    logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] vnote_q, vnote_d;
    logic [NUM_VOICES-1:0][VEL_WIDTH-1:0]  vvel_q, vvel_d;
    logic                            live_q;

    logic                            touch;
    logic [IW-1:0]                   touch_idx;
    logic [IW-1:0]                   sel;
    logic [NUM_VOICES-1:0][IW-1:0]   ages;
    logic [IW-1:0]                   oldest;

    voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_ages (
        .clk         (clk),
        .rst         (rst),
        .touch_i     (touch),
        .touch_idx_i (touch_idx),
        .ages_o      (ages),
        .oldest_o    (oldest)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        on_d          = on_q;
        note_d        = note_q;
        vel_d         = vel_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        gate_d        = gate_q;
        vnote_d       = vnote_q;
        vvel_d        = vvel_q;
        trig_d        = '0;
        steal_d       = 1'b0;
        touch         = 1'b0;
        touch_idx     = '0;
        sel           = '0;

        case (state_q)
            IDLE: begin
                if (ev_if.event_valid && live_q) begin
                    // A zero-velocity note-on is folded into a release here.
                    on_d          = ev_if.event_on && (ev_if.event_velocity != '0);
                    note_d        = ev_if.event_note;
                    vel_d         = ev_if.event_velocity;
                    idx_d         = '0;
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    free_found_d  = 1'b0;
                    free_idx_d    = '0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (gate_q[idx_q] && (vnote_q[idx_q] == note_q) && !match_found_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                if (!gate_q[idx_q] && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NUM_VOICES - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (on_q) begin
                    if (match_found_q)     sel = match_idx_q;
                    else if (free_found_q) sel = free_idx_q;
                    else                   sel = oldest;
                    gate_d[sel]  = 1'b1;
                    vnote_d[sel] = note_q;
                    vvel_d[sel]  = vel_q;
                    trig_d[sel]  = 1'b1;
                    steal_d      = !match_found_q && !free_found_q;
                    touch        = 1'b1;
                    touch_idx    = sel;
                end else if (match_found_q) begin
                    gate_d[match_idx_q] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ev_if.panic) begin
            state_d = IDLE;
            gate_d  = '0;
            trig_d  = '0;
            steal_d = 1'b0;
            touch   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            on_q          <= 1'b0;
            note_q        <= '0;
            vel_q         <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            gate_q        <= '0;
            trig_q        <= '0;
            steal_q       <= 1'b0;
            vnote_q       <= '0;
            vvel_q        <= '0;
            live_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            on_q          <= on_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            gate_q        <= gate_d;
            trig_q        <= trig_d;
            steal_q       <= steal_d;
            vnote_q       <= vnote_d;
            vvel_q        <= vvel_d;
            live_q        <= 1'b1;
        end
    end

    // live_q delays ready by one cycle so it rises only after reset release.
    assign ev_if.event_ready    = (state_q == IDLE) && live_q;
    assign ev_if.voice_gate     = gate_q;
    assign ev_if.voice_trigger  = trig_q;
    assign ev_if.voice_steal    = steal_q;
    assign ev_if.voice_note     = vnote_q;
    assign ev_if.voice_velocity = vvel_q;
    assign ev_if.fsm_state      = state_q;
    assign ev_if.voice_age      = ages;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomised and directed bench for voice_allocator against a queue-based LRU model.
module tb_voice_allocator;
    import synth_pkg::*;

    localparam int N  = 8;
    localparam int NW = 7;
    localparam int VW = 7;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_VOICES(N), .NOTE_WIDTH(NW), .VEL_WIDTH(VW)) vif ();

    voice_allocator #(.NUM_VOICES(N), .NOTE_WIDTH(NW), .VEL_WIDTH(VW)) dut (
        .clk   (clk),
        .rst   (rst),
        .ev_if (vif)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: per-voice state plus a recency list, most recent first.
    bit m_gate[N];
    int m_note[N];
    int m_vel[N];
    int order_q[$];

    task automatic model_reset();
        order_q.delete();
        for (int v = 0; v < N; v++) begin
            m_gate[v] = 0; m_note[v] = 0; m_vel[v] = 0;
            order_q.push_back(v);
        end
    endtask

    task automatic model_event(input bit on, input int note, input int vel,
                               output logic [N-1:0] trig, output bit steal);
        int m;
        int pos;
        trig  = '0;
        steal = 0;
        m     = -1;
        for (int v = 0; v < N; v++)
            if (m < 0 && m_gate[v] && m_note[v] == note) m = v;
        if (on && vel != 0) begin
            if (m < 0)
                for (int v = 0; v < N; v++)
                    if (m < 0 && !m_gate[v]) m = v;
            if (m < 0) begin
                m = order_q[$];
                steal = 1;
            end
            m_gate[m] = 1; m_note[m] = note; m_vel[m] = vel;
            trig[m] = 1'b1;
            pos = 0;
            for (int j = 0; j < order_q.size(); j++) if (order_q[j] == m) pos = j;
            order_q.delete(pos);
            order_q.push_front(m);
        end else if (m >= 0) begin
            m_gate[m] = 0;
        end
    endtask

    function automatic logic [N-1:0] exp_gate();
        for (int v = 0; v < N; v++) exp_gate[v] = m_gate[v];
    endfunction

    function automatic logic [N*NW-1:0] exp_note();
        for (int v = 0; v < N; v++) exp_note[v*NW +: NW] = NW'(m_note[v]);
    endfunction

    function automatic logic [N*VW-1:0] exp_vel();
        for (int v = 0; v < N; v++) exp_vel[v*VW +: VW] = VW'(m_vel[v]);
    endfunction

    function automatic logic [N*IW-1:0] exp_age();
        exp_age = '0;
        for (int j = 0; j < order_q.size(); j++) exp_age[order_q[j]*IW +: IW] = IW'(j);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        vif.event_valid = 1'b0;
        vif.panic = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // Drives one event and checks handshake timing and the committed result.
    task automatic send_event(input bit on, input int note, input int vel);
        int waited = 0;
        int low = 0;
        int early = 0;
        logic [N-1:0] etrig;
        bit esteal;
        @(negedge clk);
        while (vif.event_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        total_cnt++;
        if (vif.event_ready !== 1'b1) $display("FAIL ready_wait: event_ready=%b want 1", vif.event_ready);
        else pass_cnt++;
        vif.event_valid    = 1'b1;
        vif.event_on       = on;
        vif.event_note     = NW'(note);
        vif.event_velocity = VW'(vel);
        @(posedge clk);
        @(negedge clk);
        vif.event_valid = 1'b0;
        for (int k = 1; k <= N + 1; k++) begin
            if (vif.event_ready === 1'b0) low++;
            if (vif.voice_trigger !== '0) early++;
            @(negedge clk);
        end
        model_event(on, note, vel, etrig, esteal);
        total_cnt++;
        if (low != N + 1 || early != 0 || vif.event_ready !== 1'b1)
            $display("FAIL busy_window: ready low %0d cycles, early triggers %0d, ready now %b; want %0d, 0, 1",
                     low, early, vif.event_ready, N + 1);
        else pass_cnt++;
        total_cnt++;
        if (vif.voice_gate !== exp_gate()) $display("FAIL gate: got %b want %b", vif.voice_gate, exp_gate());
        else pass_cnt++;
        total_cnt++;
        if (vif.voice_note !== exp_note()) $display("FAIL note: got %h want %h", vif.voice_note, exp_note());
        else pass_cnt++;
        total_cnt++;
        if (vif.voice_velocity !== exp_vel()) $display("FAIL velocity: got %h want %h", vif.voice_velocity, exp_vel());
        else pass_cnt++;
        total_cnt++;
        if (vif.voice_trigger !== etrig || vif.voice_steal !== esteal)
            $display("FAIL trigger_steal: got %b/%b want %b/%b", vif.voice_trigger, vif.voice_steal, etrig, esteal);
        else pass_cnt++;
        total_cnt++;
        if (vif.voice_age !== exp_age()) $display("FAIL ages: got %h want %h", vif.voice_age, exp_age());
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (vif.voice_trigger !== '0 || vif.voice_steal !== 1'b0)
            $display("FAIL pulse_width: trigger %b steal %b one cycle later, want 0/0", vif.voice_trigger, vif.voice_steal);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({vif.voice_gate, vif.voice_trigger, vif.voice_steal, vif.voice_note, vif.voice_velocity, vif.event_ready} !== '0)
            $display("FAIL reset_outputs: gate %b trig %b steal %b ready %b, want all 0",
                     vif.voice_gate, vif.voice_trigger, vif.voice_steal, vif.event_ready);
        else pass_cnt++;
        model_reset();
        total_cnt++;
        if (vif.voice_age !== exp_age() || vif.fsm_state !== IDLE)
            $display("FAIL reset_state: ages %h state %0d want %h / IDLE", vif.voice_age, vif.fsm_state, exp_age());
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (vif.event_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", vif.event_ready);
        else pass_cnt++;
    endtask

    task automatic test_first_note();
        send_event(1, 60, 100);
        total_cnt++;
        if (vif.voice_gate !== 8'h01 || vif.voice_note[NW-1:0] !== 7'd60)
            $display("FAIL first_note: gate %b note0 %0d want 00000001 / 60", vif.voice_gate, vif.voice_note[NW-1:0]);
        else pass_cnt++;
    endtask

    task automatic test_note_off();
        send_event(1, 62, 90);
        send_event(0, 60, 0);
        total_cnt++;
        if (vif.voice_gate[1:0] !== 2'b10 || vif.voice_note[NW-1:0] !== 7'd60)
            $display("FAIL note_off: gate[1:0] %b note0 %0d want 10 / 60", vif.voice_gate[1:0], vif.voice_note[NW-1:0]);
        else pass_cnt++;
    endtask

    task automatic test_retrigger();
        do_reset();
        send_event(1, 10, 20);
        send_event(1, 11, 21);
        send_event(1, 12, 22);
        send_event(1, 60, 23);
        send_event(1, 60, 50);
        total_cnt++;
        if (vif.voice_velocity[3*VW +: VW] !== 7'd50 || vif.voice_gate !== 8'h0f)
            $display("FAIL retrigger: vel3 %0d gate %b want 50 / 00001111", vif.voice_velocity[3*VW +: VW], vif.voice_gate);
        else pass_cnt++;
    endtask

    task automatic test_steal();
        do_reset();
        for (int n = 40; n <= 48; n++) send_event(1, n, 64 + n - 40);
        total_cnt++;
        if (vif.voice_note[NW-1:0] !== 7'd48 || vif.voice_gate !== 8'hff)
            $display("FAIL steal_oldest: note0 %0d gate %b want 48 / 11111111", vif.voice_note[NW-1:0], vif.voice_gate);
        else pass_cnt++;
    endtask

    task automatic test_vel0_and_unheld();
        do_reset();
        send_event(1, 70, 30);
        send_event(1, 71, 31);
        send_event(1, 70, 0);
        send_event(0, 99, 10);
        total_cnt++;
        if (vif.voice_gate[1:0] !== 2'b10) $display("FAIL vel0_release: gate[1:0] %b want 10", vif.voice_gate[1:0]);
        else pass_cnt++;
    endtask

    task automatic test_panic();
        int trig_seen = 0;
        do_reset();
        for (int n = 0; n < 4; n++) send_event(1, 50 + n, 80);
        @(negedge clk);
        vif.event_valid = 1'b1; vif.event_on = 1'b1;
        vif.event_note = 7'd70; vif.event_velocity = 7'd90;
        @(posedge clk);
        @(negedge clk);
        vif.event_valid = 1'b0;
        repeat (2) @(negedge clk);
        vif.panic = 1'b1;
        @(negedge clk);
        vif.panic = 1'b0;
        for (int v = 0; v < N; v++) m_gate[v] = 0;
        total_cnt++;
        if (vif.voice_gate !== '0 || vif.voice_trigger !== '0 || vif.fsm_state !== IDLE)
            $display("FAIL panic_scan: gate %b trig %b state %0d want 0 / 0 / IDLE",
                     vif.voice_gate, vif.voice_trigger, vif.fsm_state);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (vif.event_ready !== 1'b1) $display("FAIL panic_ready: got %b want 1", vif.event_ready);
        else pass_cnt++;
        vif.event_valid = 1'b1; vif.event_note = 7'd30; vif.panic = 1'b1;
        @(negedge clk);
        vif.event_valid = 1'b0; vif.panic = 1'b0;
        total_cnt++;
        if (vif.event_ready !== 1'b1 || vif.fsm_state !== IDLE)
            $display("FAIL panic_idle: ready %b state %0d want 1 / IDLE", vif.event_ready, vif.fsm_state);
        else pass_cnt++;
        repeat (N + 4) begin
            if (vif.voice_trigger !== '0 || vif.voice_gate !== '0) trig_seen++;
            @(negedge clk);
        end
        total_cnt++;
        if (trig_seen != 0 || vif.voice_age !== exp_age())
            $display("FAIL panic_dropped: activity cycles %0d ages %h want 0 / %h", trig_seen, vif.voice_age, exp_age());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        int trig_seen = 0;
        send_event(1, 33, 44);
        @(negedge clk);
        vif.event_valid = 1'b1; vif.event_on = 1'b1;
        vif.event_note = 7'd34; vif.event_velocity = 7'd45;
        @(posedge clk);
        @(negedge clk);
        vif.event_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        total_cnt++;
        if ({vif.voice_gate, vif.voice_note, vif.voice_velocity, vif.event_ready} !== '0 || vif.voice_age !== exp_age())
            $display("FAIL reset_mid_scan: gate %b ready %b ages %h want 0 / 0 / %h",
                     vif.voice_gate, vif.event_ready, vif.voice_age, exp_age());
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        repeat (N + 4) begin
            if (vif.voice_trigger !== '0 || vif.event_ready !== 1'b1) trig_seen++;
            @(negedge clk);
        end
        total_cnt++;
        if (trig_seen != 0) $display("FAIL reset_drop: %0d cycles with trigger or not ready, want 0", trig_seen);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit on;
        int note;
        int vel;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 14) == 0) begin
                @(negedge clk);
                vif.panic = 1'b1;
                @(negedge clk);
                vif.panic = 1'b0;
                for (int v = 0; v < N; v++) m_gate[v] = 0;
                total_cnt++;
                if (vif.voice_gate !== '0) $display("FAIL random_panic: gate %b want 0", vif.voice_gate);
                else pass_cnt++;
            end
            on   = ($urandom_range(0, 3) != 0);
            note = $urandom_range(20, 31);
            vel  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
            send_event(on, note, vel);
        end
    endtask

    initial begin
        rst = 1'b0;
        vif.event_valid = 1'b0;
        vif.event_on = 1'b0;
        vif.event_note = '0;
        vif.event_velocity = '0;
        vif.panic = 1'b0;
        model_reset();
        test_reset();
        test_first_note();
        test_note_off();
        test_retrigger();
        test_steal();
        test_vel0_and_unheld();
        test_panic();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog");
    end

endmodule
